// File: rtl/gamepad_pmod_multi.sv
// Gamepad Pmod receiver/decoder for 1..4 pads: synchronised serial capture,
// frame-length validation, per-pad decode, edge events and a link watchdog.
module gamepad_pmod_multi #(
    parameter int NUM_PADS       = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pmod_data,
    input  logic                     pmod_clk,
    input  logic                     pmod_latch,
    output logic [NUM_PADS*12-1:0]   buttons,
    output logic [NUM_PADS*12-1:0]   pressed,
    output logic [NUM_PADS*12-1:0]   released,
    output logic [NUM_PADS-1:0]      is_present,
    output logic                     frame_valid,
    output logic                     frame_error,
    output logic                     stale
);

    localparam int NB = NUM_PADS * 12;
    localparam int CW = $clog2(NB + 2);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [1:0]    r_data_s;
    logic [2:0]    r_clk_s;
    logic [2:0]    r_latch_s;
    logic [NB-1:0] r_shift;
    logic [NB-1:0] r_raw;
    logic [CW-1:0] r_cnt;
    logic [TW-1:0] r_wd;
    logic          r_stale;
    logic          r_valid_p;
    logic          r_err_p;

    logic          w_clk_rise;
    logic          w_latch_rise;
    logic          w_len_ok;
    logic          w_commit;
    logic          w_timeout;
    logic [NB-1:0] w_new_buttons;
    logic [NUM_PADS-1:0] w_present;

    // Index [1] is the synchronised level, index [2] its previous value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_s  <= '0;
            r_clk_s   <= '0;
            r_latch_s <= '0;
        end else begin
            r_data_s  <= {r_data_s[0], pmod_data};
            r_clk_s   <= {r_clk_s[1:0], pmod_clk};
            r_latch_s <= {r_latch_s[1:0], pmod_latch};
        end
    end

    assign w_clk_rise   = r_clk_s[1] & ~r_clk_s[2];
    assign w_latch_rise = r_latch_s[1] & ~r_latch_s[2];

    always_comb begin
        w_len_ok = 1'b0;
        for (int unsigned k = 0; k < NUM_PADS; k++) begin
            if (r_cnt == CW'(12 * (k + 1))) w_len_ok = 1'b1;
        end
    end

    assign w_commit  = w_latch_rise & w_len_ok;
    assign w_timeout = (TIMEOUT_CYCLES > 0) && !r_stale && !w_commit &&
                       (r_wd == TW'(TIMEOUT_CYCLES - 1));

    // A clock edge coincident with the latch becomes bit 1 of the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '1;
            r_cnt     <= '0;
            r_valid_p <= 1'b0;
            r_err_p   <= 1'b0;
        end else begin
            r_valid_p <= w_commit;
            r_err_p   <= w_latch_rise & ~w_len_ok;
            if (w_latch_rise) begin
                if (w_clk_rise) begin
                    r_shift <= {{(NB-1){1'b1}}, r_data_s[1]};
                    r_cnt   <= CW'(1);
                end else begin
                    r_shift <= '1;
                    r_cnt   <= '0;
                end
            end else if (w_clk_rise) begin
                r_shift <= {r_shift[NB-2:0], r_data_s[1]};
                if (r_cnt != CW'(NB + 1)) r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raw   <= '1;
            r_wd    <= '0;
            r_stale <= 1'b1;
        end else if (w_commit) begin
            r_raw   <= r_shift;
            r_wd    <= '0;
            r_stale <= 1'b0;
        end else if (w_timeout) begin
            r_raw   <= '1;
            r_wd    <= '0;
            r_stale <= 1'b1;
        end else if (TIMEOUT_CYCLES > 0 && !r_stale) begin
            r_wd    <= r_wd + TW'(1);
        end
    end

    always_comb begin
        w_new_buttons = '0;
        w_present     = '0;
        for (int unsigned k = 0; k < NUM_PADS; k++) begin
            w_present[k] = ~&r_raw[12*k +: 12];
            if (w_present[k]) w_new_buttons[12*k +: 12] = r_raw[12*k +: 12];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buttons     <= '0;
            pressed     <= '0;
            released    <= '0;
            is_present  <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            stale       <= 1'b1;
        end else begin
            buttons     <= w_new_buttons;
            pressed     <= w_new_buttons & ~buttons;
            released    <= ~w_new_buttons & buttons;
            is_present  <= w_present;
            frame_valid <= r_valid_p;
            frame_error <= r_err_p;
            stale       <= r_stale;
        end
    end

endmodule

// File: tb/tb_gamepad_pmod_multi.sv
// Scoreboard bench for gamepad_pmod_multi (two pads, shortened watchdog).
module tb_gamepad_pmod_multi;

    localparam int NP  = 2;
    localparam int TMO = 1000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            pmod_data = 1'b0;
    logic            pmod_clk = 1'b0;
    logic            pmod_latch = 1'b0;
    logic [NP*12-1:0] buttons, pressed, released;
    logic [NP-1:0]   is_present;
    logic            frame_valid, frame_error, stale;

    gamepad_pmod_multi #(.NUM_PADS(NP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .pmod_data(pmod_data), .pmod_clk(pmod_clk),
        .pmod_latch(pmod_latch), .buttons(buttons), .pressed(pressed),
        .released(released), .is_present(is_present), .frame_valid(frame_valid),
        .frame_error(frame_error), .stale(stale)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 valid, 1 error, 2 timeout
        logic [23:0] btn;
        logic [23:0] pr;
        logic [23:0] rl;
        logic [1:0]  pres;
        logic        st;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   chk_cnt = 0;
    int   err_cnt = 0;
    int   cyc = 0;
    int   last_fv = 0;
    logic stale_d = 1'b1;

    logic [23:0] m_btn = '0;
    logic [1:0]  m_pres = '0;
    logic        m_stale = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s obs=%0h exp=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        exp_t e;
        int   kind;
        if (rst_n) begin
            if (frame_valid || frame_error || (stale && !stale_d)) begin
                check_eq("sb_nonempty", 32'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    kind = frame_valid ? 0 : (frame_error ? 1 : 2);
                    check_eq("event_kind", kind, e.kind);
                    if (e.kind == 2) check_eq("wd_cycles", cyc - last_fv, TMO);
                    else             check_eq("latency", cyc, e.cyc);
                    check_eq("buttons", 32'(buttons), 32'(e.btn));
                    check_eq("is_present", 32'(is_present), 32'(e.pres));
                    check_eq("pressed", 32'(pressed), 32'(e.pr));
                    check_eq("released", 32'(released), 32'(e.rl));
                    check_eq("stale", 32'(stale), 32'(e.st));
                end
                if (frame_valid) last_fv = cyc;
            end else begin
                check_eq("idle_pulses", 32'((|pressed) | (|released)), 0);
            end
        end
        stale_d <= stale;
    end

    function automatic void decode(input logic [23:0] raw, output logic [23:0] b, output logic [1:0] p);
        logic [11:0] s;
        b = '0;
        p = '0;
        for (int k = 0; k < NP; k++) begin
            s = raw[12*k +: 12];
            if (s != 12'hFFF) begin
                p[k] = 1'b1;
                b[12*k +: 12] = s;
            end
        end
    endfunction

    // Expectation for a latch driven this cycle, n bits of v (last bit in v[0]).
    task automatic push_frame(input int n, input logic [47:0] v);
        exp_t        e;
        logic [47:0] t;
        logic [23:0] nb;
        logic [1:0]  np;
        e.cyc = cyc + 4;
        if (n > 0 && n % 12 == 0 && n <= NP * 12) begin
            t = ({48{1'b1}} << n) | v;
            decode(t[23:0], nb, np);
            e.kind = 0;
            e.pr = nb & ~m_btn;
            e.rl = ~nb & m_btn;
            m_btn = nb;
            m_pres = np;
            m_stale = 1'b0;
        end else begin
            e.kind = 1;
            e.pr = '0;
            e.rl = '0;
        end
        e.btn = m_btn;
        e.pres = m_pres;
        e.st = m_stale;
        q.push_back(e);
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        pmod_data = b;
        wait_neg(4);
        pmod_clk = 1'b1;
        wait_neg(4);
        pmod_clk = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [47:0] v);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
        wait_neg(2);
        push_frame(n, v);
        pmod_latch = 1'b1;
        wait_neg(4);
        pmod_latch = 1'b0;
        wait_neg(8);
    endtask

    initial begin
        exp_t e;
        wait_neg(3);
        check_eq("rst_buttons", 32'(buttons), 0);
        check_eq("rst_present", 32'(is_present), 0);
        check_eq("rst_stale", 32'(stale), 1);
        rst_n = 1'b1;
        wait_neg(4);
        check_eq("post_rst_stale", 32'(stale), 1);

        send_frame(24, 48'hFFF800);
        check_eq("hold_buttons", 32'(buttons), 32'h000800);

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_buttons", 32'(buttons), 0);
        check_eq("async_present", 32'(is_present), 0);
        check_eq("async_stale", 32'(stale), 1);
        check_eq("async_strobes", 32'({frame_valid, frame_error}), 0);
        m_btn = '0; m_pres = '0; m_stale = 1'b1;
        wait_neg(3);
        rst_n = 1'b1;
        wait_neg(4);

        send_frame(24, 48'hFFF800);
        send_frame(12, 48'h001);
        send_frame(12, 48'h000);
        send_frame(13, 48'h1ABC);
        check_eq("err_hold", 32'(buttons), 32'h000000);
        send_frame(12, 48'h456);
        send_frame(36, 48'h123456789);
        send_frame(24, 48'h0A5F0F);

        // Coincident pmod_clk and pmod_latch edge
        for (int i = 11; i >= 0; i--) send_bit(12'h123 >> i);
        pmod_data = 1'b1;
        wait_neg(4);
        push_frame(12, 48'h123);
        pmod_clk = 1'b1;
        pmod_latch = 1'b1;
        wait_neg(4);
        pmod_clk = 1'b0;
        pmod_latch = 1'b0;
        wait_neg(4);
        for (int i = 10; i >= 0; i--) send_bit(11'h0A5 >> i);
        wait_neg(2);
        push_frame(12, 48'h8A5);
        pmod_latch = 1'b1;
        wait_neg(4);
        pmod_latch = 1'b0;
        wait_neg(8);

        // Watchdog: pad0 holds a, then the link goes quiet
        send_frame(12, 48'h008);
        e.kind = 2; e.btn = '0; e.pres = '0; e.pr = '0; e.rl = m_btn; e.st = 1'b1; e.cyc = 0;
        q.push_back(e);
        m_btn = '0; m_pres = '0; m_stale = 1'b1;
        wait_neg(TMO + 20);
        check_eq("wd_stale_level", 32'(stale), 1);
        send_frame(24, 48'h00C801);

        wait_neg(10);
        check_eq("sb_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/gamepad_pmod_multi.md
# gamepad_pmod_multi

Parametrised serial receiver and decoder for the Gamepad Pmod supporting 1–4 controllers in one block. It receives the Pmod's clock/data/latch stream, validates frame length, and decodes the buttons of each pad. It adds one-cycle press/release event pulses, a frame-valid strobe, a frame-error strobe, and a link watchdog that drops all pads to "not present" when latches stop arriving. It sits between the Pmod input pins and game logic, replacing per-design driver/decoder pairs.

## Interface
- NUM_PADS, 2, number of controllers decoded (1..4)
- TIMEOUT_CYCLES, 1000000, clk cycles without a valid frame before the link is declared stale; 0 disables the watchdog
- clk  input  1  system clock
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- pmod_data  input  1  serial data from Pmod (asynchronous)
- pmod_clk  input  1  serial bit clock from Pmod (asynchronous)
- pmod_latch  input  1  frame latch from Pmod (asynchronous)
- buttons  output  NUM_PADS*12  pad k at [12k+11:12k], order {b,y,select,start,up,down,left,right,a,x,l,r} MSB→LSB; 1 = pressed
- pressed  output  NUM_PADS*12  one-cycle pulse per bit on 0→1 of buttons
- released  output  NUM_PADS*12  one-cycle pulse per bit on 1→0 of buttons
- is_present  output  NUM_PADS  pad k connected
- frame_valid  output  1  one-cycle strobe, valid frame committed
- frame_error  output  1  one-cycle strobe, malformed frame discarded
- stale  output  1  no valid frame within TIMEOUT_CYCLES (or none since reset)

## Operation
- All three pins pass through 2-flop synchronisers, then a prev-flop for rising-edge detection. All state is asynchronously reset by rst_n.
- On each pmod_clk rising edge: shift_reg (NUM_PADS*12 bits, LSB-in) shifts in the data bit, and bit_cnt increments, saturating at NUM_PADS*12+1.
- On each pmod_latch rising edge, the frame closes:
  - valid if bit_cnt is a nonzero multiple of 12 and ≤ NUM_PADS*12;
  - valid: raw <= shift_reg; frame_valid pulses; watchdog clears; stale <= 0;
  - invalid (count 0, non-multiple, or overflow): raw unchanged, frame_error pulses, watchdog keeps counting.
  - In both cases shift_reg <= all 1s and bit_cnt <= 0.
  - Consequence: pads beyond the bits sent read 0xFFF (absent); the last 12 bits shifted always land in pad 0.
- Simultaneous clk and latch edges in one cycle: the frame commits without that bit. The bit becomes bit 1 of the new frame (shift_reg = {all 1s, bit}, bit_cnt = 1).
- Decode per pad: slice == 12'hFFF → is_present[k]=0 and buttons slice = 0; otherwise is_present[k]=1 and buttons slice = raw slice.
- pressed = new_buttons & ~buttons and released = ~new_buttons & buttons. Both are registered in the same cycle buttons updates and are zero in every other cycle.
- Watchdog (TIMEOUT_CYCLES>0):
  - counter increments every cycle while stale=0;
  - on reaching TIMEOUT_CYCLES: raw <= all 1s, stale <= 1, and released pulses for every button held.
  - A later valid frame recovers normally.
- Reset mid-frame: partial frame is lost; a frame's trailing bits after reset, when latched, yield frame_error unless the count is coincidentally valid.

## Timing
- Reset values:
  - buttons, pressed, released, is_present, frame_valid, frame_error = 0;
  - stale = 1;
  - internal raw and shift_reg = all 1s; bit_cnt and watchdog = 0.
- Pin-to-detect latency: an edge first sampled at clk edge n is acted on at edge n+2. Registered outputs (buttons, is_present, pressed, released, frame_valid, frame_error, stale) change at edge n+3.
- buttons/is_present hold between commits; no handshake, strobes are not stretched.
- Minimum pmod_clk high and low time: 3 clk cycles for guaranteed capture.
- Timeout fires exactly TIMEOUT_CYCLES cycles after the commit cycle of the last valid frame.

## Test plan
- Reset: assert rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately, stale=1.
- NUM_PADS=2, send 24 bits with pad1=0xFFF, pad0=0x800 (b pressed), then latch -> frame_valid pulse 3 cycles after latch, is_present=2'b01, buttons=24'h000800, pressed[11]=1 for one cycle, stale=0.
- Single-pad frame on NUM_PADS=2: 12 bits 0x001, latch -> buttons[11:0]=0x001, is_present=2'b01. Send 0x000 next -> released[0] pulses once.
- Malformed: 13 bits, latch -> frame_error pulse, buttons unchanged. 36 bits (overflow) -> frame_error.
- Coincident edges: pmod_clk and pmod_latch rise together -> frame commits without that bit, and the next frame with 11 further bits + latch is valid.
- Watchdog with TIMEOUT_CYCLES=100 and pad0 holding a=1: no latch for 100 cycles -> stale=1, is_present=0, buttons=0, released[3] pulses once. The next valid frame clears stale.
